// File: rtl/data_mem_access_unit_pkg.sv
// ----------------------------------------------------------------------------
// data_mem_access_unit_pkg
// Shared definitions for the data memory access unit:
//   - default address/data widths matching the 256 x 8 data memory
//   - burst length field width (beats = len + 1)
//   - controller state encoding
// ----------------------------------------------------------------------------
package data_mem_access_unit_pkg;

    localparam int DMAU_ADDR_W = 8;
    localparam int DMAU_DATA_W = 8;
    localparam int DMAU_LEN_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RD_EN     = 3'd1,
        ST_RD_RESP   = 3'd2,
        ST_WR_DATA   = 3'd3,
        ST_WR_STROBE = 3'd4,
        ST_WR_RECOV  = 3'd5,
        ST_DONE      = 3'd6
    } dmau_state_e;

endpackage : data_mem_access_unit_pkg

// File: rtl/data_mem_access_unit_mem_burst_counter.sv
// ----------------------------------------------------------------------------
// data_mem_access_unit_mem_burst_counter
// Burst bookkeeping for the access unit: a wrapping address incrementer and
// a remaining-beat down-counter. Load takes priority over step.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_load      : capture i_addr / i_len as the start of a new burst
//   i_step      : advance to the next beat (addr+1 modulo 2^ADDR_W, count-1)
//   i_addr      : burst start address
//   i_len       : beats minus one
//   o_addr      : current beat address (register output)
//   o_last      : current beat is the final one (count == 0)
// ----------------------------------------------------------------------------
module data_mem_access_unit_mem_burst_counter
    import data_mem_access_unit_pkg::*;
#(
    parameter int ADDR_W = DMAU_ADDR_W,
    parameter int LEN_W  = DMAU_LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_step,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [LEN_W-1:0]  i_len,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);

    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_count;

    // Address and beat counter; the address wraps naturally at its width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= {ADDR_W{1'b0}};
            r_count <= {LEN_W{1'b0}};
        end else if (i_load) begin
            r_addr  <= i_addr;
            r_count <= i_len;
        end else if (i_step) begin
            r_addr  <= r_addr + ADDR_W'(1);
            r_count <= r_count - LEN_W'(1);
        end else begin
            r_addr  <= r_addr;
            r_count <= r_count;
        end
    end

    assign o_addr = r_addr;
    assign o_last = (r_count == {LEN_W{1'b0}});

endmodule : data_mem_access_unit_mem_burst_counter

// File: rtl/data_mem_access_unit.sv
// ----------------------------------------------------------------------------
// data_mem_access_unit
// Initiator-side controller for the 256 x 8 data memory. Accepts single or
// burst load/store commands over valid/ready, drives the memory's
// level-sensitive strobes with setup/recovery cycles around each write, and
// returns load data through a backpressured stream.
//
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   req_valid/req_ready        : command handshake (req_write, req_addr, req_len)
//   wr_valid/wr_ready/wr_data  : store data beats
//   rd_valid/rd_ready/rd_data  : load data beats, rd_last marks the final beat
//   done                       : one-cycle pulse when a burst completes
//   enable_write/enable_read   : memory strobes (registered, never both high)
//   ram_addr/write_data        : memory address and write data (registered)
//   read_data                  : memory read data
// ----------------------------------------------------------------------------
module data_mem_access_unit
    import data_mem_access_unit_pkg::*;
#(
    parameter int ADDR_W  = DMAU_ADDR_W,
    parameter int DATA_W  = DMAU_DATA_W,
    parameter int LEN_W   = DMAU_LEN_W,
    parameter int RD_WAIT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              done,
    output logic              enable_write,
    output logic              enable_read,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data
);

    localparam logic [1:0] LP_RD_WAIT = 2'(RD_WAIT);

    dmau_state_e       r_state;
    logic              r_req_ready;
    logic              r_wr_ready;
    logic              r_rd_valid;
    logic              r_rd_last;
    logic              r_done;
    logic              r_enable_write;
    logic              r_enable_read;
    logic [DATA_W-1:0] r_rd_data;
    logic [DATA_W-1:0] r_write_data;
    logic [1:0]        r_wait;

    logic              w_load;
    logic              w_step;
    logic              w_last;
    logic [ADDR_W-1:0] w_addr;

    // Command accepted only on the registered ready, so a busy unit holds it off.
    assign w_load = (r_state == ST_IDLE) && req_valid && r_req_ready;

    // Advance on a consumed non-final load beat or after a non-final write recovery.
    assign w_step = ((r_state == ST_RD_RESP) && rd_ready && !w_last) ||
                    ((r_state == ST_WR_RECOV) && !w_last);

    data_mem_access_unit_mem_burst_counter #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_burst_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_step (w_step),
        .i_addr (req_addr),
        .i_len  (req_len),
        .o_addr (w_addr),
        .o_last (w_last)
    );

    // Controller FSM; every output is set on the edge that enters its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_req_ready    <= 1'b0;
            r_wr_ready     <= 1'b0;
            r_rd_valid     <= 1'b0;
            r_rd_last      <= 1'b0;
            r_done         <= 1'b0;
            r_enable_write <= 1'b0;
            r_enable_read  <= 1'b0;
            r_rd_data      <= {DATA_W{1'b0}};
            r_write_data   <= {DATA_W{1'b0}};
            r_wait         <= 2'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_load) begin
                        r_req_ready <= 1'b0;
                        if (req_write) begin
                            r_state    <= ST_WR_DATA;
                            r_wr_ready <= 1'b1;
                        end else begin
                            r_state       <= ST_RD_EN;
                            r_enable_read <= 1'b1;
                            r_wait        <= LP_RD_WAIT;
                        end
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                ST_RD_EN: begin
                    // Hold enable_read for 1+RD_WAIT cycles, sample on the last edge.
                    if (r_wait == 2'd0) begin
                        r_rd_data     <= read_data;
                        r_enable_read <= 1'b0;
                        r_rd_valid    <= 1'b1;
                        r_rd_last     <= w_last;
                        r_state       <= ST_RD_RESP;
                    end else begin
                        r_wait <= r_wait - 2'd1;
                    end
                end
                ST_RD_RESP: begin
                    if (rd_ready) begin
                        r_rd_valid <= 1'b0;
                        r_rd_last  <= 1'b0;
                        if (w_last) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state       <= ST_RD_EN;
                            r_enable_read <= 1'b1;
                            r_wait        <= LP_RD_WAIT;
                        end
                    end else begin
                        r_state <= ST_RD_RESP;
                    end
                end
                ST_WR_DATA: begin
                    if (wr_valid) begin
                        r_write_data   <= wr_data;
                        r_wr_ready     <= 1'b0;
                        r_enable_write <= 1'b1;
                        r_state        <= ST_WR_STROBE;
                    end else begin
                        r_state <= ST_WR_DATA;
                    end
                end
                ST_WR_STROBE: begin
                    r_enable_write <= 1'b0;
                    r_state        <= ST_WR_RECOV;
                end
                ST_WR_RECOV: begin
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state    <= ST_WR_DATA;
                        r_wr_ready <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state        <= ST_IDLE;
                    r_req_ready    <= 1'b0;
                    r_wr_ready     <= 1'b0;
                    r_rd_valid     <= 1'b0;
                    r_rd_last      <= 1'b0;
                    r_enable_write <= 1'b0;
                    r_enable_read  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready    = r_req_ready;
    assign wr_ready     = r_wr_ready;
    assign rd_valid     = r_rd_valid;
    assign rd_last      = r_rd_last;
    assign rd_data      = r_rd_data;
    assign done         = r_done;
    assign enable_write = r_enable_write;
    assign enable_read  = r_enable_read;
    assign ram_addr     = w_addr;
    assign write_data   = r_write_data;

endmodule : data_mem_access_unit

// File: doc/data_mem_access_unit.md
Name: data_mem_access_unit

Overview:
- Initiator-side controller for the 256 x 8 data memory.
- Accepts single or burst load/store commands from the datapath over a valid/ready handshake.
- Drives the memory's level-sensitive enable_write/enable_read/ram_addr/write_data pins with safe timing, captures read_data into a register and streams it back with backpressure.
- Sits between the CPU datapath (or a copy engine) and the data memory.

Parameters:
- ADDR_W, 8, address width; the burst address wraps modulo 2^ADDR_W.
- DATA_W, 8, data width.
- LEN_W, 4, burst-length field width; beats = req_len + 1, so 1..16.
- RD_WAIT, 0, extra cycles enable_read is held before sampling read_data (0..3).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  command valid.
- req_ready  out  1  command accepted when req_valid & req_ready.
- req_write  in  1  1 = store burst, 0 = load burst.
- req_addr  in  ADDR_W  start address.
- req_len  in  LEN_W  beats minus one.
- wr_valid  in  1  store data beat valid.
- wr_ready  out  1  store data beat accepted.
- wr_data  in  DATA_W  store data.
- rd_valid  out  1  load data beat valid.
- rd_ready  in  1  consumer accepts load beat.
- rd_data  out  DATA_W  load data.
- rd_last  out  1  final beat of a load burst, qualified by rd_valid.
- done  out  1  one-cycle pulse when the burst completes.
- enable_write  out  1  to memory.
- enable_read  out  1  to memory.
- ram_addr  out  ADDR_W  to memory.
- write_data  out  DATA_W  to memory.
- read_data  in  DATA_W  from memory.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset values: while rst_n=0, every output is 0 and the state is IDLE. This includes req_ready, and enable_write/enable_read drop immediately without waiting for a clock edge.
- Register rules: all memory-side outputs are registered. ram_addr and write_data never change in a cycle where enable_write=1.
- States: IDLE, RD_EN, RD_RESP, WR_DATA, WR_STROBE, WR_RECOV, DONE.
- IDLE:
  - req_ready=1.
  - On handshake, latch addr, req_write and beat counter = req_len.
  - Go to WR_DATA if req_write=1, else RD_EN.
- RD_EN:
  - enable_read=1, ram_addr=current addr, held for 1+RD_WAIT cycles.
  - read_data is sampled into rd_data on the last of those edges.
  - Then go to RD_RESP with enable_read=0.
- RD_RESP:
  - rd_valid=1; rd_last=1 when counter=0.
  - rd_data is stable until rd_ready.
  - On rd_ready: if counter=0, go to DONE. Otherwise decrement the counter, addr=addr+1 (wrapping 0xFF->0x00), and go to RD_EN.
- Load latency: a command accepted at edge 0 gives the first rd_valid in cycle 2+RD_WAIT. Each further beat costs 2+RD_WAIT cycles when rd_ready is held high.
- WR_DATA:
  - wr_ready=1.
  - On wr_valid, latch wr_data into write_data and ram_addr=addr, then go to WR_STROBE.
  - Stalls indefinitely while wr_valid=0.
- WR_STROBE: enable_write=1 for exactly one cycle, with address and data held.
- WR_RECOV:
  - enable_write=0, address and data still held (one recovery cycle).
  - Then if counter=0 go to DONE; else decrement, addr+1 (wrapping), and go to WR_DATA.
- Store timing: 3 cycles per beat minimum.
- DONE: done=1 for one cycle, then IDLE. req_ready stays 0 in this state, so back-to-back commands have a 1-cycle gap.
- Mutual exclusion: enable_write and enable_read are never both 1.
- Handshake outputs:
  - wr_ready=1 only in WR_DATA.
  - rd_valid=1 only in RD_RESP.
  - req_ready=0 in every state except IDLE; a req_valid arriving while busy is held off, not dropped.
- Ignored inputs: wr_valid during a load and rd_ready outside RD_RESP are ignored.
- Reset mid-burst: the burst is abandoned and no done is issued. If a write strobe was in flight, it is truncated (reset asserted while enable_write=1 counts as partial).

Decomposition:
- Shared package holds:
  - the state encoding enum;
  - ADDR_W/DATA_W defaults matching the data memory;
  - the LEN_W constant.
- One natural sub-module: mem_burst_counter. It holds the address incrementer with wrap plus the beat down-counter, with load/step inputs and a last flag.
- The FSM stays in the top module.

Test Plan:
- Single store, then single load:
  - Store addr 0x10, len 0, data 0xA5, then load 0x10 len 0.
  - Expect enable_write high for exactly 1 cycle with ram_addr=0x10 and write_data=0xA5.
  - Expect rd_data=0xA5 with rd_last=1, then a done pulse.
- Reset-value load: load addr 0x00 len 1 from the reset image. Expect beats 0x48 then 0x08, rd_last only on the second beat.
- Wrapping store burst:
  - Store burst addr 0xFE len 2 with data 0x11, 0x22, 0x33.
  - Expect write strobes at 0xFE, 0xFF, 0x00, and readback to match.
- Backpressure:
  - Load burst of 4 with rd_ready toggling 1-0-0-1.
  - Expect rd_data stable while stalled, no extra enable_read strobes, and exactly 4 beats.
- Store stall and held-off command:
  - During a store, drop wr_valid for 5 cycles. Expect enable_write=0 and wr_ready=1 throughout the stall.
  - Assert req_valid mid-burst. Expect req_ready=0 until after done.
- Reset mid-operation:
  - Pull rst_n low in WR_STROBE of a 3-beat store. Expect all outputs at 0 immediately and no done.
  - After release, a load of beats 0..2 shows only the completed beats updated.
